load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's memory stage and the word-addressed `RAM`, converting byte-addressed RISC-V loads and stores into word accesses. Loads use byte/halfword lane extraction with sign or zero extension. SB/SH use a read-modify-write sequence, because the RAM only writes whole words. Misaligned, out-of-range or illegal-funct3 requests are rejected with an error response and never touch the RAM.

## Interface
- `RAM_DEPTH`, 256: number of 32-bit words in the attached RAM; sets the legal address range.

Ports:
- `clk` in 1: single clock; all state changes on the posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; low byte/halfword used for SB/SH.
- `resp_valid` out 1: one-cycle pulse, request complete.
- `resp_rdata` out 32: load result (extended); 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; request rejected.
- `ram_re` out 1: RAM read enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out 32: word index, `{2'b0, addr[31:2]}`.
- `ram_wdata` out 32: word to write.
- `ram_rdata` in 32: RAM read data, combinational from `ram_addr` while `ram_re` is high.

## Operation
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- Request acceptance:
  - A handshake occurs when `req_valid && req_ready`.
  - On handshake, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- Error check at accept; if any of the following holds, go to RESP with `err=1`:
  - Word index `addr[31:2] >= RAM_DEPTH`.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Halfword access (LH/LHU/SH) with `addr[0]` set.
  - Word access (LW/SW) with `addr[1:0]` nonzero.
- Legal requests branch as follows:
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD.
- LOAD:
  - Drive `ram_re=1` and `ram_addr`.
  - At the edge, capture the extracted lane into `resp_rdata` and go to RESP.
- WRITE:
  - Drive `ram_we=1` and `ram_wdata=wdata`.
  - At the edge, go to RESP.
- RMW_RD:
  - Drive `ram_re=1`.
  - At the edge, register the merged word: `ram_rdata` with the target lane replaced by the store data.
  - Go to RMW_WR.
- RMW_WR:
  - Drive `ram_we=1` with the merged word.
  - At the edge, go to RESP.
- RESP:
  - `resp_valid=1` for exactly one cycle; `resp_err` per the latched flag.
  - Then return to IDLE. There is no response backpressure.
- Lanes are little-endian:
  - Byte k occupies bits [8k+7:8k], with k = `addr[1:0]`.
  - Halfword h occupies bits [16h+15:16h], with h = `addr[1]`.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through unchanged.
- RAM-side outputs:
  - `ram_re` and `ram_we` are decoded from the state register only; they are never both high.
  - `ram_addr` and `ram_wdata` hold their last value outside access states.
- Reset values (asynchronous, applied immediately):
  - State IDLE.
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`.
  - `ram_re=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
  - `req_ready=1`; requests are ignored while `rst_n` is low.
- Reset mid-operation:
  - Any in-flight request is abandoned and no response is issued.
  - If reset hits in RMW_RD or earlier, the RAM word is unchanged.

## Timing
- Cycle 0 is the accept edge.
- Response latency from accept:
  - Error: `resp_valid` high in cycle 1.
  - Load and SW: `resp_valid` high in cycle 2.
  - SB/SH: `resp_valid` high in cycle 3.
- `req_ready` is low from cycle 1 until the cycle after RESP.
- Minimum spacing between accepts:
  - 2 cycles for errors.
  - 3 cycles for loads and SW.
  - 4 cycles for SB/SH.
- `ram_we` is high for exactly one cycle per store; an RMW read is always followed by exactly one write.
- `resp_rdata` is stable during the `resp_valid` cycle and holds its value afterwards until the next response.

## Test plan
- Loads, with RAM word 3 preloaded with 0x8765F0A1:
  - LB 0x0C → 0xFFFFFFA1.
  - LBU 0x0D → 0x000000F0.
  - LH 0x0E → 0xFFFF8765.
  - LHU 0x0C → 0x0000F0A1.
  - Each has `resp_valid` at accept+2 and `resp_err=0`.
- SB 0x0D with wdata 0x123456AB:
  - `ram_re` for 1 cycle, then `ram_we` with `ram_addr`=3 and `ram_wdata`=0x8765ABA1; response at accept+3.
  - A following LW 0x0C returns 0x8765ABA1.
- Stores on fresh RAM contents:
  - SH 0x0E with 0x0000CAFE writes word 3 = 0xCAFEF0A1.
  - SW 0x10 with 0xDEADBEEF gives exactly one `ram_we` cycle at `ram_addr`=4 and response at accept+2.
- Error cases:
  - LW 0x0D, LH 0x0F, load funct3 011, and LW 0x400 (word 256) each give `resp_valid=1`, `resp_err=1`, `resp_rdata=0` at accept+1.
  - `ram_re` and `ram_we` are never asserted for any of them.
- Back-to-back:
  - With `req_valid` held high across three LW requests, `req_ready` drops while busy and accepts occur every 3 cycles.
  - No request is lost or duplicated.
- Reset mid-RMW:
  - Drive `rst_n` low during RMW_RD of an SB.
  - All outputs go to reset values immediately, the RAM word is unchanged, and no `resp_valid` is seen.
  - After release, `req_ready=1` and the next LW works.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response bus of the load/store unit.
//   master : the core's memory stage (drives requests, receives responses)
//   slave  : the load/store unit
// Signals:
//   req_valid/req_ready : request handshake
//   req_we, req_funct3, req_addr, req_wdata : request payload
//   resp_valid, resp_rdata, resp_err        : one-cycle completion pulse
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RISC-V loads/stores into accesses
// on a word-addressed RAM. Sub-word loads extract and extend a lane;
// sub-word stores do read-modify-write since the RAM writes whole words.
// Misaligned, out-of-range and illegal-funct3 requests are answered with
// an error and never reach the RAM.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : core request/response bus (slave side)
//   ram_re      : RAM read enable
//   ram_we      : RAM write enable
//   ram_addr    : RAM word index
//   ram_wdata   : RAM write word
//   ram_rdata   : RAM read word (combinational from ram_addr)
module load_store_unit #(
    parameter int RAM_DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    load_store_unit_if.slave       bus,
    output logic                   ram_re,
    output logic                   ram_we,
    output logic [31:0]            ram_addr,
    output logic [31:0]            ram_wdata,
    input  logic [31:0]            ram_rdata
);

    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;     // addr[1:0] of the accepted request
    logic [15:0] wdata_q;    // only the low halfword is needed after accept
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic        f3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) && err_q;

    // Request legality, evaluated on the live request at the accept edge.
    assign out_of_range = {2'b00, bus.req_addr[31:2]} >= 32'(RAM_DEPTH);

    always_comb begin
        f3_bad     = 1'b0;
        misaligned = 1'b0;
        if (bus.req_we)
            f3_bad = (bus.req_funct3 > 3'b010);
        else
            f3_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign req_err = out_of_range || f3_bad || misaligned;

    // Load lane extraction with sign/zero extension.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = ram_rdata[{lane_q, 3'b000} +: 8];
        h = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{b[7]}}, b};
            3'b001:  load_val = {{16{h[15]}}, h};
            3'b100:  load_val = {24'h0, b};
            3'b101:  load_val = {16'h0, h};
            default: load_val = ram_rdata;
        endcase
    end

    // RMW merge: funct3[0] distinguishes SH from SB.
    always_comb begin
        merged = ram_rdata;
        if (funct3_q[0])
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        else
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // RAM strobes are decoded from state only, so they cannot overlap.
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                      state_nxt = RESP;
                    else if (!bus.req_we)             state_nxt = LOAD;
                    else if (bus.req_funct3 == 3'b010) state_nxt = WRITE;
                    else                              state_nxt = RMW_RD;
                end
            end
            LOAD:   begin ram_re = 1'b1; state_nxt = RESP;   end
            WRITE:  begin ram_we = 1'b1; state_nxt = RESP;   end
            RMW_RD: begin ram_re = 1'b1; state_nxt = RMW_WR; end
            RMW_WR: begin ram_we = 1'b1; state_nxt = RESP;   end
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers. ram_addr/ram_wdata only move on legal accepts
    // and in RMW_RD, so rejected requests leave the RAM port untouched.
    // resp_rdata changes only on the edge into RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q       <= 3'b000;
            lane_q         <= 2'b00;
            wdata_q        <= 16'h0;
            err_q          <= 1'b0;
            ram_addr       <= 32'h0;
            ram_wdata      <= 32'h0;
            bus.resp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= bus.req_funct3;
                        lane_q   <= bus.req_addr[1:0];
                        wdata_q  <= bus.req_wdata[15:0];
                        err_q    <= req_err;
                        if (req_err) begin
                            bus.resp_rdata <= 32'h0;
                        end else begin
                            ram_addr <= {2'b00, bus.req_addr[31:2]};
                            if (bus.req_we && bus.req_funct3 == 3'b010)
                                ram_wdata <= bus.req_wdata;
                        end
                    end
                end
                LOAD:   bus.resp_rdata <= load_val;
                WRITE:  bus.resp_rdata <= 32'h0;
                RMW_RD: ram_wdata      <= merged;
                RMW_WR: bus.resp_rdata <= 32'h0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 256-word RAM model (combinational read, write on posedge).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_re, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_data = 32'h0;

    int checks = 0;
    int failures = 0;

    // results of the last do_req
    int          lat, n_re, n_we, n_both;
    logic [31:0] rd, w_addr, w_data;
    logic        er, acc_ready;

    load_store_unit_if bus();

    load_store_unit #(.RAM_DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram_re ? mem[ram_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we)     mem[ram_addr[7:0]] <= ram_wdata;
        else if (pl_we) mem[pl_idx]        <= pl_data;
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Issue one request, then watch 8 cycles after the accept edge.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        acc_ready = bus.req_ready;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; n_re = 0; n_we = 0; n_both = 0;
        rd = 32'hDEADDEAD; er = 1'bx; w_addr = 32'hx; w_data = 32'hx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ram_re) n_re++;
            if (ram_we) begin n_we++; w_addr = ram_addr; w_data = ram_wdata; end
            if (ram_re && ram_we) n_both++;
            if (bus.resp_valid && lat < 0) begin
                lat = k; rd = bus.resp_rdata; er = bus.resp_err;
            end
        end
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, ram_re, ram_we} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=10000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, ram_re, ram_we});
        end
        checks++;
        if (ram_addr !== 32'h0) begin failures++; $display("FAIL reset_ram_addr got=%h want=0", ram_addr); end
        checks++;
        if (ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_ram_wdata got=%h want=0", ram_wdata); end
        checks++;
        if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.resp_rdata); end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] a   [4] = '{32'h0C, 32'h0D, 32'h0E, 32'h0C};
        logic [31:0] exp [4] = '{32'hFFFFFFA1, 32'h000000F0, 32'hFFFF8765, 32'h0000F0A1};
        preload(8'd3, 32'h8765F0A1);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3[i], a[i], 32'h0);
            checks++;
            if (rd !== exp[i]) begin failures++; $display("FAIL load%0d_data got=%h want=%h", i, rd, exp[i]); end
            checks++;
            if (lat != 2 || er !== 1'b0 || n_re != 1 || n_we != 0) begin
                failures++;
                $display("FAIL load%0d_timing lat=%0d err=%b re=%0d we=%0d want lat=2 err=0 re=1 we=0",
                         i, lat, er, n_re, n_we);
            end
        end
    endtask

    task automatic test_sb;
        do_req(1'b1, 3'b000, 32'h0D, 32'h123456AB);
        checks++;
        if (n_re != 1 || n_we != 1 || n_both != 0) begin
            failures++; $display("FAIL sb_strobes re=%0d we=%0d both=%0d want 1 1 0", n_re, n_we, n_both);
        end
        checks++;
        if (w_addr !== 32'd3 || w_data !== 32'h8765ABA1) begin
            failures++; $display("FAIL sb_write addr=%h data=%h want 3 8765aba1", w_addr, w_data);
        end
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
            failures++; $display("FAIL sb_resp lat=%0d err=%b rdata=%h want 3 0 0", lat, er, rd);
        end
        do_req(1'b0, 3'b010, 32'h0C, 32'h0);
        checks++;
        if (rd !== 32'h8765ABA1 || lat != 2) begin
            failures++; $display("FAIL sb_readback got=%h lat=%0d want 8765aba1 2", rd, lat);
        end
    endtask

    task automatic test_stores;
        preload(8'd3, 32'h8765F0A1);
        do_req(1'b1, 3'b001, 32'h0E, 32'h0000CAFE);
        checks++;
        if (mem[3] !== 32'hCAFEF0A1 || lat != 3 || n_we != 1) begin
            failures++; $display("FAIL sh_word got=%h lat=%0d we=%0d want cafef0a1 3 1", mem[3], lat, n_we);
        end
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++;
        if (n_we != 1 || n_re != 0 || w_addr !== 32'd4 || w_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_write we=%0d re=%0d addr=%h data=%h want 1 0 4 deadbeef", n_we, n_re, w_addr, w_data);
        end
        checks++;
        if (lat != 2 || er !== 1'b0 || mem[4] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL sw_resp lat=%0d err=%b mem=%h want 2 0 deadbeef", lat, er, mem[4]);
        end
    endtask

    task automatic test_errors;
        logic        we [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b011};
        logic [31:0] a  [5] = '{32'h0D, 32'h0F, 32'h0C, 32'h400, 32'h0};
        for (int i = 0; i < 5; i++) begin
            do_req(we[i], f3[i], a[i], 32'hFFFFFFFF);
            checks++;
            if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
                failures++; $display("FAIL err%0d_resp lat=%0d err=%b rdata=%h want 1 1 0", i, lat, er, rd);
            end
            checks++;
            if (n_re != 0 || n_we != 0) begin
                failures++; $display("FAIL err%0d_ram re=%0d we=%0d want 0 0", i, n_re, n_we);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3] = '{32'h11112222, 32'h33334444, 32'h55556666};
        int acc_cyc [3];
        logic [31:0] got [3];
        int nacc = 0, nresp = 0, busy_seen = 0;
        logic acc;
        for (int i = 0; i < 3; i++) preload(8'(5 + i), vals[i]);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h14; bus.req_wdata = 32'h0;
        for (int c = 0; c < 20; c++) begin
            if (bus.resp_valid && nresp < 3) begin got[nresp] = bus.resp_rdata; nresp++; end
            if (bus.req_valid && !bus.req_ready) busy_seen++;
            acc = bus.req_valid && bus.req_ready;
            if (acc && nacc < 3) begin acc_cyc[nacc] = c; nacc++; end
            @(posedge clk); #1;
            if (acc) begin
                if (nacc < 3) bus.req_addr = 32'h14 + 32'(4 * nacc);
                else          bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checks++;
        if (nacc != 3 || nresp != 3) begin
            failures++; $display("FAIL b2b_count accepts=%0d resps=%0d want 3 3", nacc, nresp);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
                failures++; $display("FAIL b2b_spacing got=%0d,%0d want 3,3",
                                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== vals[i]) begin
                    failures++; $display("FAIL b2b_data%0d got=%h want=%h", i, got[i], vals[i]);
                end
            end
        end
        checks++;
        if (busy_seen != 4) begin
            failures++; $display("FAIL b2b_ready_low got=%0d want=4", busy_seen);
        end
    endtask

    task automatic test_reset_mid_rmw;
        int resp_seen = 0;
        preload(8'd8, 32'hAABBCCDD);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h21; bus.req_wdata = 32'h00000011;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_re !== 1'b1) begin failures++; $display("FAIL rst_rmw_rd got re=%b want 1", ram_re); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.resp_valid, ram_re, ram_we} !== 4'b1000 ||
            ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs ctrl=%b addr=%h wdata=%h want 1000 0 0",
                     {bus.req_ready, bus.resp_valid, ram_re, ram_we}, ram_addr, ram_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.resp_valid) resp_seen++;
        end
        checks++;
        if (resp_seen != 0 || mem[8] !== 32'hAABBCCDD || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_after resp=%0d mem=%h ready=%b want 0 aabbccdd 1",
                     resp_seen, mem[8], bus.req_ready);
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0);
        checks++;
        if (rd !== 32'hAABBCCDD || lat != 2 || er !== 1'b0) begin
            failures++; $display("FAIL rst_mid_lw got=%h lat=%0d err=%b want aabbccdd 2 0", rd, lat, er);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_loads();
        checks++;
        if (acc_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b want=1", acc_ready); end
        test_sb();
        test_stores();
        test_errors();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
